// File: rtl/status_cond_unit.sv
// status_cond_unit: architectural status register plus ARM condition
// evaluator. It produces a registered execute/squash decision for the
// instruction leaving ID and keeps saturating pass/fail statistics.
//
// Output handshake: cond_pass_valid is a valid-only qualifier with no ready.
// cond_pass is meaningful only while cond_pass_valid=1. Both outputs hold
// their value during a stall and drop to 0 on a flush. The consumer samples
// them on every edge.
module status_cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sr_wr_en,
    input  logic [3:0]       sr_wr_data,
    input  logic [3:0]       cond,
    input  logic             cond_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [3:0]       sr,
    output logic             cond_pass,
    output logic             cond_pass_valid,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0] flags;
    logic       flag_z;
    logic       flag_c;
    logic       flag_n;
    logic       flag_v;
    logic       eval;
    logic       advance;
    logic       count_en;

    // Bypass: a flag write in EXE is visible to the condition in ID this cycle
    always_comb begin
        flags  = sr_wr_en ? sr_wr_data : sr;
        flag_z = flags[3];
        flag_c = flags[2];
        flag_n = flags[1];
        flag_v = flags[0];
    end

    // Condition field decode against the effective flags
    always_comb begin
        eval = 1'b0;
        case (cond)
            4'h0:    eval = flag_z;
            4'h1:    eval = !flag_z;
            4'h2:    eval = flag_c;
            4'h3:    eval = !flag_c;
            4'h4:    eval = flag_n;
            4'h5:    eval = !flag_n;
            4'h6:    eval = flag_v;
            4'h7:    eval = !flag_v;
            4'h8:    eval = flag_c && !flag_z;
            4'h9:    eval = !flag_c || flag_z;
            4'hA:    eval = (flag_n == flag_v);
            4'hB:    eval = (flag_n != flag_v);
            4'hC:    eval = !flag_z && (flag_n == flag_v);
            4'hD:    eval = flag_z || (flag_n != flag_v);
            4'hE:    eval = 1'b1;
            default: eval = 1'b0;
        endcase
    end

    // Decision stage moves only when neither killed nor held
    always_comb begin
        advance  = !flush && !stall;
        count_en = advance && cond_valid;
    end

    // Status register: written whenever EXE sets flags, regardless of stall/flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= 4'b0000;
        end else if (sr_wr_en) begin
            sr <= sr_wr_data;
        end
    end

    // Decision register: flush clears, stall holds, otherwise capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond_pass       <= 1'b0;
            cond_pass_valid <= 1'b0;
        end else if (flush) begin
            cond_pass       <= 1'b0;
            cond_pass_valid <= 1'b0;
        end else if (!stall) begin
            cond_pass       <= cond_valid && eval;
            cond_pass_valid <= cond_valid;
        end
    end

    // Saturating statistics, counting only evaluations that actually advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_count <= '0;
            fail_count <= '0;
        end else if (count_en) begin
            if (eval && (pass_count != CNT_MAX)) begin
                pass_count <= pass_count + 1'b1;
            end
            if (!eval && (fail_count != CNT_MAX)) begin
                fail_count <= fail_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_status_cond_unit.sv
// Bench for status_cond_unit: directed test-plan sequences plus random
// traffic, checked against a flag/condition model through an expected queue.
// A second instance with 2-bit counters exercises saturation.
module tb_status_cond_unit;

    localparam int W = 42;

    logic        clk;
    logic        rst;
    logic        sr_wr_en;
    logic [3:0]  sr_wr_data;
    logic [3:0]  cond;
    logic        cond_valid;
    logic        stall;
    logic        flush;

    logic [3:0]  sr;
    logic        cond_pass;
    logic        cond_pass_valid;
    logic [15:0] pass_count;
    logic [15:0] fail_count;

    logic [3:0]  sr2;
    logic        cond_pass2;
    logic        cond_pass_valid2;
    logic [1:0]  pass_count2;
    logic [1:0]  fail_count2;

    logic [W-1:0] exp_q[$];
    int n_vec;
    int n_miss;

    // model state
    logic [3:0] m_sr;
    logic       m_pass;
    logic       m_valid;
    int         m_total_pass;
    int         m_total_fail;

    status_cond_unit #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .sr_wr_en(sr_wr_en), .sr_wr_data(sr_wr_data),
        .cond(cond), .cond_valid(cond_valid), .stall(stall), .flush(flush),
        .sr(sr), .cond_pass(cond_pass), .cond_pass_valid(cond_pass_valid),
        .pass_count(pass_count), .fail_count(fail_count)
    );

    status_cond_unit #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .sr_wr_en(sr_wr_en), .sr_wr_data(sr_wr_data),
        .cond(cond), .cond_valid(cond_valid), .stall(stall), .flush(flush),
        .sr(sr2), .cond_pass(cond_pass2), .cond_pass_valid(cond_pass_valid2),
        .pass_count(pass_count2), .fail_count(fail_count2)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ARM conditions come in complementary pairs: bits [3:1] pick a
    // predicate, bit 0 inverts it. 0xE is always, 0xF never.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit z;
        bit cy;
        bit n;
        bit v;
        bit base;
        z  = f[3];
        cy = f[2];
        n  = f[1];
        v  = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? ~base : base;
    endfunction

    function automatic int sat(input int x, input int max_val);
        return (x > max_val) ? max_val : x;
    endfunction

    task automatic model_reset();
        m_sr         = 4'b0000;
        m_pass       = 1'b0;
        m_valid      = 1'b0;
        m_total_pass = 0;
        m_total_fail = 0;
    endtask

    // drive one cycle, advance the model at the edge, push the expected outputs
    task automatic step(input logic we, input logic [3:0] wd, input logic [3:0] c,
                        input logic cv, input logic st, input logic fl);
        logic [3:0] f;
        bit e;
        logic [W-1:0] pkt;
        sr_wr_en   = we;
        sr_wr_data = wd;
        cond       = c;
        cond_valid = cv;
        stall      = st;
        flush      = fl;
        @(posedge clk);
        f = we ? wd : m_sr;
        e = cond_holds(c, f);
        if (we) m_sr = wd;
        if (fl) begin
            m_pass  = 1'b0;
            m_valid = 1'b0;
        end else if (!st) begin
            m_valid = cv;
            m_pass  = cv & e;
            if (cv) begin
                if (e) m_total_pass++;
                else   m_total_fail++;
            end
        end
        pkt = {m_sr, m_valid, m_pass,
               16'(sat(m_total_pass, 65535)), 16'(sat(m_total_fail, 65535)),
               2'(sat(m_total_pass, 3)), 2'(sat(m_total_fail, 3))};
        exp_q.push_back(pkt);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        logic [W-1:0] act;
        act = {sr, cond_valid & 1'b0 | cond_pass_valid, cond_pass, pass_count, fail_count,
               pass_count2, fail_count2};
        n_vec++;
        if (act != '0 || sr2 != 4'b0 || cond_pass2 || cond_pass_valid2) begin
            n_miss++;
            $display("FAIL %s: outputs=%h sr2=%h pass2=%b valid2=%b, required all zero",
                     name, act, sr2, cond_pass2, cond_pass_valid2);
        end
    endtask

    // asynchronous reset applied between edges, checked before any edge
    task automatic apply_reset(input string name);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero(name);
        exp_q.delete();
        model_reset();
        sr_wr_en   = 1'b0;
        cond_valid = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic cmp_field(input string name, input logic [15:0] act,
                             input logic [15:0] req, inout bit bad);
        if (act !== req) begin
            bad = 1'b1;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // monitor: compare DUT outputs to the oldest expectation each cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            bit bad;
            e   = exp_q.pop_front();
            bad = 1'b0;
            cmp_field("sr",              16'(sr),              16'(e[41:38]), bad);
            cmp_field("cond_pass_valid", 16'(cond_pass_valid), 16'(e[37]),    bad);
            cmp_field("cond_pass",       16'(cond_pass),       16'(e[36]),    bad);
            cmp_field("pass_count",      pass_count,           e[35:20],      bad);
            cmp_field("fail_count",      fail_count,           e[19:4],       bad);
            cmp_field("pass_count_w2",   16'(pass_count2),     16'(e[3:2]),   bad);
            cmp_field("fail_count_w2",   16'(fail_count2),     16'(e[1:0]),   bad);
            n_vec++;
            if (bad) n_miss++;
        end
    end

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        rst        = 1'b1;
        sr_wr_en   = 1'b0;
        sr_wr_data = 4'b0;
        cond       = 4'b0;
        cond_valid = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        model_reset();
        #2;
        check_all_zero("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // AL for three cycles
        repeat (3) step(1'b0, 4'h0, 4'hE, 1'b1, 1'b0, 1'b0);

        // bypass: Z written in the same cycle as EQ, then NE
        step(1'b1, 4'b1000, 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'b1000, 4'h1, 1'b1, 1'b0, 1'b0);
        // bypass must beat stale sr: clear Z while testing EQ
        step(1'b1, 4'b0000, 4'h0, 1'b1, 1'b0, 1'b0);

        // full sweep of conditions against held flags
        for (int f = 0; f < 16; f++) begin
            step(1'b1, 4'(f), 4'h0, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                step(1'b0, 4'h0, 4'(c), 1'b1, 1'b0, 1'b0);
            end
        end

        // pass, then stall two cycles with flag writes and a never-condition
        step(1'b0, 4'h0, 4'hE, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 4'hF, 1'b1, 1'b1, 1'b0);
        step(1'b1, 4'b0100, 4'hF, 1'b1, 1'b1, 1'b0);
        step(1'b0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0);

        // flush beats stall, and a bubble
        step(1'b0, 4'h0, 4'hE, 1'b1, 1'b1, 1'b1);
        step(1'b0, 4'h0, 4'hE, 1'b0, 1'b0, 1'b0);

        // mid-stream reset, then saturation of the 2-bit counters
        step(1'b1, 4'b1111, 4'hE, 1'b1, 1'b0, 1'b0);
        apply_reset("mid_reset");
        repeat (5) step(1'b0, 4'h0, 4'hE, 1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);

        // random traffic with a reset partway through
        for (int i = 0; i < 600; i++) begin
            if (i == 300) apply_reset("random_reset");
            step($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), $urandom_range(0, 7) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
        end
        sr_wr_en   = 1'b0;
        cond_valid = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
